bram_be_dp: RTL

Byte-enabled, single-clock, simple dual-port block RAM with hardware clear and an optional output pipeline register. It generalises the basic ICE40 BRAM used by the RV32 core in four ways:
- per-byte write enables, for SB/SH stores;
- write-first read-during-write forwarding;
- a read-valid strobe;
- a sequenced memory clear, run at reset or on request, so the core never reads uninitialised data.

It sits between the core's load/store unit and the ICE40 EBR primitives.

---
 rtl/bram_be_dp_if.sv | 26 ++
 rtl/bram_be_dp.sv | 115 +++++++++++
 2 files changed

// File: rtl/bram_be_dp_if.sv
// Load/store-unit side of the byte-enabled RAM: write/read strobes, clear request and read return.
// Master drives requests, slave returns busy/rdata/rvalid; no backpressure beyond busy.
interface bram_be_dp_if #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 256,
  parameter int BYTE_W    = 8
);
  localparam int NB = WORD_SIZE / BYTE_W;
  localparam int AW = $clog2(DEPTH);

  logic                 clr;
  logic                 busy;
  logic                 wen;
  logic [NB-1:0]        wbe;
  logic [AW-1:0]        waddr;
  logic [WORD_SIZE-1:0] wdata;
  logic                 ren;
  logic [AW-1:0]        raddr;
  logic [WORD_SIZE-1:0] rdata;
  logic                 rvalid;

  modport master (output clr, wen, wbe, waddr, wdata, ren, raddr,
                  input  busy, rdata, rvalid);
  modport slave  (input  clr, wen, wbe, waddr, wdata, ren, raddr,
                  output busy, rdata, rvalid);
endinterface

// File: rtl/bram_be_dp.sv
// Byte-enabled simple dual-port RAM with write-first forwarding and sequenced clear; read latency 1 (+1 with OUT_REG).
// No backpressure: one read per cycle; while busy all wen/ren/clr are dropped.
module bram_be_dp #(
  parameter int WORD_SIZE      = 32,
  parameter int DEPTH          = 256,
  parameter int BYTE_W         = 8,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic        clk,
  input logic        rst,
  bram_be_dp_if.slave bus
);
  localparam int NB = WORD_SIZE / BYTE_W;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        cnt, cnt_nxt;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [WORD_SIZE-1:0] rd_word;
  logic [WORD_SIZE-1:0] r1_dat;
  logic                 r1_vld;
  logic                 idle, wr_go, rd_go;

  assign idle     = (state == IDLE);
  assign wr_go    = idle && bus.wen;
  assign rd_go    = idle && bus.ren;
  assign bus.busy = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Termination is detected at the last address so the counter never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) mem[bus.waddr][i*BYTE_W +: BYTE_W] <= bus.wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Write-first: enabled lanes of a same-cycle write to the read address bypass the array.
  always_comb begin
    rd_word = mem[bus.raddr];
    if (wr_go && (bus.waddr == bus.raddr)) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wbe[i]) rd_word[i*BYTE_W +: BYTE_W] = bus.wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_dat <= '0;
      r1_vld <= 1'b0;
    end else begin
      r1_vld <= rd_go;
      if (rd_go) r1_dat <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WORD_SIZE-1:0] r2_dat;
      logic                 r2_vld;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r2_dat <= '0;
          r2_vld <= 1'b0;
        end else begin
          r2_vld <= r1_vld;
          if (r1_vld) r2_dat <= r1_dat;
        end
      end
      assign bus.rdata  = r2_dat;
      assign bus.rvalid = r2_vld;
    end else begin : g_noreg
      assign bus.rdata  = r1_dat;
      assign bus.rvalid = r1_vld;
    end
  endgenerate
endmodule
